imem_program_loader: RTL and testbench

- Loads a program image into the pipelined machine's instruction memory from a 32-bit valid/ready word stream.
- Holds the CPU in reset until the image has been written and its checksum verified, then releases it.
- It is the write-in counterpart to the end-of-run state dump: it fills state before execution, where the dump reads state out after execution.
- Sits between an external host or boot stream and the instruction memory write port / CPU reset input.

---
 rtl/imem_program_loader.sv | 132 +++++++++++++
 tb/tb_imem_program_loader.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
// imem_program_loader
// Streams a program image (header, data words, checksum) from a 32-bit
// valid/ready source into instruction memory, holding the CPU in reset until
// the image checksum matches.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   in_valid/in_data      - input word stream
//   in_ready              - stream accept (transfer = in_valid & in_ready)
//   reload                - pulse: restart loading from RUN or ERR
//   imem_we/addr/wdata    - instruction memory write port (registered)
//   cpu_reset             - high unless the image is loaded and verified
//   load_error            - high while a load has failed
//   words_loaded          - data words written in the current load
module imem_program_loader #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              load_error,
    output logic [15:0]       words_loaded
);

    localparam int unsigned DEPTH_I = 1 << ADDR_W;
    localparam logic [16:0] DEPTH   = 17'(DEPTH_I);

    typedef enum logic [2:0] {
        S_HDR,
        S_LOAD,
        S_CHK,
        S_RUN,
        S_ERR
    } state_t;

    state_t            state;
    state_t            nxt;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       remaining;
    logic [31:0]       sum;

    logic              xfer;
    logic [15:0]       hdr_base;
    logic [15:0]       hdr_count;
    logic [16:0]       hdr_end;
    logic              hdr_bad;

    assign xfer      = in_valid & in_ready;
    assign hdr_base  = in_data[31:16];
    assign hdr_count = in_data[15:0];
    // 17-bit sum so an image ending exactly at DEPTH is representable
    assign hdr_end   = {1'b0, hdr_base} + {1'b0, hdr_count};
    assign hdr_bad   = ({1'b0, hdr_base} >= DEPTH) || (hdr_end > DEPTH);

    // Next-state selection
    always_comb begin
        nxt = state;
        case (state)
            S_HDR: begin
                if (xfer) begin
                    if (hdr_bad)                 nxt = S_ERR;
                    else if (hdr_count == 16'd0) nxt = S_CHK;
                    else                         nxt = S_LOAD;
                end
            end
            S_LOAD:  if (xfer && remaining == 16'd1) nxt = S_CHK;
            S_CHK:   if (xfer) nxt = (in_data == sum) ? S_RUN : S_ERR;
            S_RUN,
            S_ERR:   if (reload) nxt = S_HDR;
            default: nxt = S_HDR;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_HDR;
            in_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_reset    <= 1'b1;
            load_error   <= 1'b0;
            words_loaded <= '0;
            addr         <= '0;
            remaining    <= '0;
            sum          <= '0;
        end else begin
            state      <= nxt;
            // Outputs track the state being entered so they line up with it
            in_ready   <= (nxt == S_HDR) || (nxt == S_LOAD) || (nxt == S_CHK);
            cpu_reset  <= (nxt != S_RUN);
            load_error <= (nxt == S_ERR);
            imem_we    <= 1'b0;
            case (state)
                S_HDR: begin
                    if (xfer) begin
                        addr         <= hdr_base[ADDR_W-1:0];
                        remaining    <= hdr_count;
                        sum          <= '0;
                        words_loaded <= '0;
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        imem_we      <= 1'b1;
                        imem_addr    <= addr;
                        imem_wdata   <= in_data;
                        // Header check keeps the last write below DEPTH
                        addr         <= addr + ADDR_W'(1);
                        sum          <= sum + in_data;
                        remaining    <= remaining - 16'd1;
                        words_loaded <= words_loaded + 16'd1;
                    end
                end
                S_RUN,
                S_ERR: begin
                    if (reload) words_loaded <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader
// Randomized and directed image loads compared every cycle against a
// transaction-level model of the loader, plus literal expectations for the
// documented example images.
module tb_imem_program_loader;

    localparam int unsigned ADDR_W = 10;
    localparam int          DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [31:0]       in_data = '0;
    logic              in_ready;
    logic              reload = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              load_error;
    logic [15:0]       words_loaded;

    imem_program_loader #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .reload      (reload),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .cpu_reset   (cpu_reset),
        .load_error  (load_error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit started  = 0;
    bit rnd_reload = 0;

    // DUT write log captured at every negedge
    int          wq_addr[$];
    logic [31:0] wq_data[$];
    int          wq_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    // phase: 0 await header, 1 receiving data, 2 await checksum, 3 running, 4 failed
    int          m_phase = 0;
    int          m_next_addr = 0;
    int          m_left = 0;
    logic [31:0] m_sum = '0;
    bit          m_ready = 0;
    bit          m_we = 0;
    int          m_addr = 0;
    logic [31:0] m_wdata = '0;
    bit          m_cpu = 1;
    bit          m_err = 0;
    int          m_words = 0;

    always @(posedge clk) begin
        int base, cnt;
        bit xfer;
        cyc++;
        if (reset) begin
            m_phase = 0; m_ready = 0; m_we = 0; m_addr = 0; m_wdata = '0;
            m_cpu = 1; m_err = 0; m_words = 0;
            started = 1;
        end else begin
            xfer = in_valid && m_ready;
            m_we = 0;
            if (m_phase == 0 && xfer) begin
                base = int'(in_data[31:16]);
                cnt  = int'(in_data[15:0]);
                m_words = 0;
                m_sum = '0;
                if (base >= DEPTH || base + cnt > DEPTH) m_phase = 4;
                else if (cnt == 0) m_phase = 2;
                else begin
                    m_phase = 1; m_next_addr = base; m_left = cnt;
                end
            end else if (m_phase == 1 && xfer) begin
                m_we = 1; m_addr = m_next_addr; m_wdata = in_data;
                m_next_addr++; m_sum = m_sum + in_data; m_left--; m_words++;
                if (m_left == 0) m_phase = 2;
            end else if (m_phase == 2 && xfer) begin
                m_phase = (in_data == m_sum) ? 3 : 4;
            end else if ((m_phase == 3 || m_phase == 4) && reload) begin
                m_phase = 0; m_words = 0;
            end
            m_ready = (m_phase <= 2);
            m_cpu   = (m_phase != 3);
            m_err   = (m_phase == 4);
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (started) begin
            check("in_ready",     32'(in_ready),     32'(m_ready));
            check("imem_we",      32'(imem_we),      32'(m_we));
            check("imem_addr",    32'(imem_addr),    32'(m_addr));
            check("imem_wdata",   imem_wdata,        m_wdata);
            check("cpu_reset",    32'(cpu_reset),    32'(m_cpu));
            check("load_error",   32'(load_error),   32'(m_err));
            check("words_loaded", 32'(words_loaded), 32'(m_words));
            if (imem_we === 1'b1) begin
                wq_addr.push_back(int'(imem_addr));
                wq_data.push_back(imem_wdata);
                wq_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- stimulus helpers (all start and end at a negedge) ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 0;
            in_data  = $urandom;
            reload   = rnd_reload && ($urandom_range(0, 5) == 0);
            @(negedge clk);
        end
        reload = 0;
    endtask

    task automatic push(input logic [31:0] d, input int gap);
        int guard = 0;
        idle(gap);
        in_valid = 1;
        in_data  = d;
        while (in_ready !== 1'b1) begin
            @(negedge clk);
            guard++;
            if (guard > 50) begin
                $display("FAIL push_timeout: got in_ready=%0b expected 1 within 50 cycles", in_ready);
                n_checks++;
                break;
            end
        end
        reload = rnd_reload && ($urandom_range(0, 5) == 0);
        @(negedge clk);
        in_valid = 0;
        reload   = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        @(negedge clk);
        reset = 0;
    endtask

    task automatic pulse_reload();
        reload = 1;
        @(negedge clk);
        reload = 0;
    endtask

    task automatic clear_log();
        wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    endtask

    logic [31:0] img [3];
    logic [31:0] s;
    int base, cnt;
    bit bad;

    initial begin
        img[0] = 32'h20080005; img[1] = 32'h20090007; img[2] = 32'h01095020;
        @(negedge clk);
        do_reset();
        // reset values
        check("rst_in_ready",  32'(in_ready),     32'd0);
        check("rst_cpu_reset", 32'(cpu_reset),    32'd1);
        check("rst_imem_we",   32'(imem_we),      32'd0);
        check("rst_words",     32'(words_loaded), 32'd0);

        // good 3-word image at address 0, in_valid held high
        clear_log();
        push(32'h00000003, 0);
        for (int i = 0; i < 3; i++) push(img[i], 0);
        push(32'h411A502C, 0);
        check("ok_cpu_reset",  32'(cpu_reset),    32'd0);
        check("ok_load_error", 32'(load_error),   32'd0);
        check("ok_words",      32'(words_loaded), 32'd3);
        check("ok_nwrites",    32'(wq_addr.size()), 32'd3);
        for (int i = 0; i < 3 && i < wq_addr.size(); i++) begin
            check("ok_addr", 32'(wq_addr[i]), 32'(i));
            check("ok_data", wq_data[i], img[i]);
        end
        if (wq_cyc.size() == 3) check("ok_b2b", 32'(wq_cyc[2] - wq_cyc[0]), 32'd2);

        // bad checksum, then reload
        pulse_reload();
        clear_log();
        push(32'h00000003, 0);
        for (int i = 0; i < 3; i++) push(img[i], 0);
        push(32'h411A502D, 0);
        check("bad_load_error", 32'(load_error), 32'd1);
        check("bad_cpu_reset",  32'(cpu_reset),  32'd1);
        check("bad_nwrites",    32'(wq_addr.size()), 32'd3);
        pulse_reload();
        check("rl_load_error", 32'(load_error), 32'd0);
        check("rl_in_ready",   32'(in_ready),   32'd1);
        check("rl_words",      32'(words_loaded), 32'd0);

        // header running past the end of memory
        clear_log();
        push(32'h03FE0003, 0);
        in_valid = 1; in_data = 32'h12345678;
        @(negedge clk); @(negedge clk);
        in_valid = 0;
        check("ovf_load_error", 32'(load_error), 32'd1);
        check("ovf_in_ready",   32'(in_ready),   32'd0);
        check("ovf_nwrites",    32'(wq_addr.size()), 32'd0);

        // image ending exactly at DEPTH
        pulse_reload();
        clear_log();
        push(32'h03FD0003, 0);
        for (int i = 0; i < 3; i++) push(img[i], 0);
        push(32'h411A502C, 0);
        check("edge_cpu_reset", 32'(cpu_reset), 32'd0);
        check("edge_nwrites",   32'(wq_addr.size()), 32'd3);
        for (int i = 0; i < 3 && i < wq_addr.size(); i++)
            check("edge_addr", 32'(wq_addr[i]), 32'(1021 + i));

        // empty image
        pulse_reload();
        clear_log();
        push(32'h00050000, 0);
        push(32'h00000000, 0);
        check("empty_cpu_reset", 32'(cpu_reset), 32'd0);
        check("empty_nwrites",   32'(wq_addr.size()), 32'd0);

        // gapped transfers: valid pattern 1,0,0,1,0,1
        pulse_reload();
        push(32'h00000003, 0);
        clear_log();
        push(img[0], 0);
        push(img[1], 2);
        push(img[2], 1);
        push(32'h411A502C, 0);
        check("gap_nwrites", 32'(wq_addr.size()), 32'd3);
        if (wq_cyc.size() == 3) begin
            check("gap_d1", 32'(wq_cyc[1] - wq_cyc[0]), 32'd3);
            check("gap_d2", 32'(wq_cyc[2] - wq_cyc[1]), 32'd2);
            check("gap_addr2", 32'(wq_addr[2]), 32'd2);
            check("gap_data1", wq_data[1], img[1]);
        end

        // reset in the middle of a 4-word load
        pulse_reload();
        push(32'h00000004, 0);
        push(32'h00000011, 0);
        push(32'h00000022, 0);
        do_reset();
        check("mid_imem_we",   32'(imem_we),      32'd0);
        check("mid_words",     32'(words_loaded), 32'd0);
        check("mid_cpu_reset", 32'(cpu_reset),    32'd1);
        push(32'h00000003, 0);
        for (int i = 0; i < 3; i++) push(img[i], 0);
        push(32'h411A502C, 0);
        check("mid_reload_ok", 32'(cpu_reset), 32'd0);

        // randomized images with idle gaps and stray reload pulses
        rnd_reload = 1;
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 3) == 0) do_reset();
            else pulse_reload();
            base = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1000, 1100))
                                               : int'($urandom_range(0, 1015));
            cnt  = int'($urandom_range(0, 8));
            bad  = (base >= DEPTH) || (base + cnt > DEPTH);
            push({16'(base), 16'(cnt)}, int'($urandom_range(0, 2)));
            if (!bad) begin
                s = '0;
                for (int k = 0; k < cnt; k++) begin
                    logic [31:0] d;
                    d = $urandom;
                    s = s + d;
                    push(d, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
                end
                push(($urandom_range(0, 3) == 0) ? (s ^ 32'h1) : s, int'($urandom_range(0, 1)));
            end
            idle(2);
        end
        rnd_reload = 0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
